// File: rtl/sumator_serial_param.sv
// Chunk-serial adder: adds CHUNK bits per cycle, valid/ready in and out.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, [sub if SUMATOR_SUB_EN],
//   out_valid/out_ready, sum, cout, ovf.
module sumator_serial_param #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUMATOR_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("sumator_serial_param: WIDTH must be >=2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx;
  logic             last;
  logic [CHUNK-1:0] ca, cb, cs;
  logic             cn;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is a + ~b + 1, folded into the operands at accept.
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
`ifdef SUMATOR_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign last = (idx == IW'(N - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ca = a_q[idx*CHUNK +: CHUNK];
    cb = b_q[idx*CHUNK +: CHUNK];
    {cn, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (in_valid && in_ready) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (state == CALC) begin
      sum_q[idx*CHUNK +: CHUNK] <= cs;
      carry_q <= cn;
      idx     <= idx + 1'b1;
      if (last) begin
        cout_q <= cn;
        // carry into MSB recovered from the MSB sum bit
        ovf_q  <= cn ^ (ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sumator_serial_param.sv
// Bench for sumator_serial_param (WIDTH=8, CHUNK=2).
// Vector table, corner sequences and random ops vs. arithmetic model.
module tb_sumator_serial_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sumator_serial_param #(.WIDTH(W), .CHUNK(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUMATOR_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   t;
    logic         v;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
    v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  // Accept one op; returns the edge count from accept to out_valid.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, output int lat);
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    a = x; b = y; cin = c; sub = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] exp);
    check({tag, "_sum"},  32'(sum),  32'(exp[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    check({tag, "_ovf"},  32'(ovf),  32'(exp[W+1]));
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] la, lb;
    logic lc, ls;
    logic [W+1:0] exp;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    vecs.push_back('{8'h0C, 8'h0F, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
`ifdef SUMATOR_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    #10 rst_n = 1'b1;

    // first op accepted on the first edge after release
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      release_op();
    end

    // backpressure: result held for 10 cycles
    start_op(8'h3C, 8'h5A, 1'b1, 1'b0, lat);
    exp = model(8'h3C, 8'h5A, 1'b1, 1'b0);
    check("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      check_result($sformatf("bp%0d", k), exp);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    release_op();
    check_result("bp_after", exp);

    // reset in CALC aborts the operation
    a = 8'hFF; b = 8'h00; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_partial_sum", 32'(sum), 32'h0F);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_sum_later", 32'(sum), 32'd0);

    // operands and in_valid toggling during CALC/DONE are ignored
    la = 8'hA7; lb = 8'h6D; lc = 1'b1;
    a = la; b = lb; cin = lc; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
      lat++;
    end
    check("tog_latency", 32'(lat), 32'd4);
    a = W'($urandom); b = W'($urandom);
    tick();
    check("tog_held", 32'(out_valid), 32'd1);
    check_result("tog", model(la, lb, lc, 1'b0));
    in_valid = 1'b0;
    release_op();

    // random ops with random consumer stalls
    for (int n = 0; n < 40; n++) begin
      la = W'($urandom); lb = W'($urandom); lc = 1'($urandom);
      ls = 1'b0;
`ifdef SUMATOR_SUB_EN
      ls = 1'($urandom);
`endif
      start_op(la, lb, lc, ls, lat);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) tick();
      check_result($sformatf("rnd%0d", n), model(la, lb, lc, ls));
      release_op();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sumator_serial_param.md
SUMATOR_SERIAL_PARAM -- requirements
Module: sumator_serial_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and sum width in bits (>= 2).
REQ-002 The block SHALL have parameter CHUNK, default 2, bits added per clock cycle; WIDTH % CHUNK != 0 SHALL be rejected at elaboration.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operands present.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands (two's complement for ovf).
REQ-008 The block SHALL have port cin, input, 1, carry-in.
REQ-009 The block SHALL have port out_valid, output, 1, result held and valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 The block SHALL have port sum, output, WIDTH, result.
REQ-012 The block SHALL have port cout, output, 1, carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1, signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; N = WIDTH/CHUNK.
REQ-015 In IDLE the block SHALL drive in_ready=1; in CALC and DONE in_ready=0.
REQ-016 On an edge with in_valid && in_ready, the block SHALL latch a, b and cin, clear the chunk index and sum register, and enter CALC.
REQ-017 In CALC, each edge SHALL add chunk i of a and b plus the running carry, writing sum bits [i*CHUNK +: CHUNK], LSB chunk first.
REQ-018 After N CALC edges the block SHALL enter DONE with out_valid=1, so out_valid rises exactly N edges after the accepting edge (4 for WIDTH=8, CHUNK=2).
REQ-019 cout SHALL be the carry out of bit WIDTH-1; ovf SHALL be (carry into MSB) XOR (carry out of MSB).
REQ-020 sum, cout and ovf SHALL be stable while out_valid=1 and SHALL remain valid until the next accept.
REQ-021 In DONE, out_valid && out_ready SHALL return the block to IDLE on that edge; without out_ready it SHALL hold indefinitely (backpressure).
REQ-022 Input changes during CALC or DONE SHALL NOT affect the result; in_valid in those states SHALL be ignored, with no queueing.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with the carry held in a 1-bit register between chunks.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, and sum=0, cout=0, ovf=0, asynchronously and in any state.
REQ-025 A reset during CALC or DONE SHALL abort the operation; no result SHALL be presented after release.
REQ-026 The block SHALL be able to accept operands on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro SUMATOR_SUB_EN defined, the block SHALL add input port sub (1 bit), latched at accept.
REQ-028 With SUMATOR_SUB_EN defined and sub=1, the block SHALL compute a + ~b + 1, ignoring cin; cout=1 SHALL mean no borrow, and ovf SHALL be the signed subtraction overflow.
REQ-029 With SUMATOR_SUB_EN undefined, the block SHALL have no sub port and only add.

Verification (WIDTH=8, CHUNK=2)
REQ-030 The bench SHALL check: reset then a=0x0C, b=0x0F, cin=0 accepted -> after 4 edges out_valid=1, sum=0x1B, cout=0, ovf=0.
REQ-031 The bench SHALL check: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-032 The bench SHALL check: out_ready=0 for 10 cycles after out_valid -> sum held and in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 The bench SHALL check: rst_n pulsed low after 2 CALC edges -> out_valid=0, sum=0 at once, and no result appears later.
REQ-034 The bench SHALL check: a and b toggled every cycle during CALC -> result matches the operands latched at accept.
REQ-035 The bench SHALL check, with SUMATOR_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0.
